ysyx_22050612_imem: RTL and testbench

Instruction-memory responder for the single-cycle core: answers instruction fetch requests addressed by the core's PC with the 32-bit instruction word at that address. It sits outside the core and drives the core's instruction input. One request is outstanding at a time, and response latency is a parameter. A backdoor write port lets the bench or loader preload program images.

---
 rtl/ysyx_22050612_imem_pkg.sv | 20 ++
 rtl/ysyx_22050612_imem_array.sv | 36 +++
 rtl/ysyx_22050612_imem.sv | 134 +++++++++++++
 tb/tb_ysyx_22050612_imem.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050612_imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package ysyx_22050612_imem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte address of word 0 of the program image.
    localparam logic [63:0] DEFAULT_BASE = 64'h8000_0000;

    // Word returned alongside a fetch fault.
    localparam logic [31:0] FAULT_INST = 32'h0000_0000;

    // Latency countdown width; it covers LATENCY-2 for LATENCY up to 8.
    localparam int CNT_W = 3;

endpackage

// File: rtl/ysyx_22050612_imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port and one
// registered read port. A write and a read of the same word on the same
// edge return the old contents.
module ysyx_22050612_imem_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_reg;

    // Backdoor write; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read; holds its value between reads so responses stay stable.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ysyx_22050612_imem.sv
// Instruction-memory responder: accepts one fetch at a time, waits a
// programmable number of cycles, then presents the instruction word (or a
// fault) until the consumer takes it.
module ysyx_22050612_imem
    import ysyx_22050612_imem_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = DEFAULT_BASE,
    parameter int          LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_err,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_idx,
    input  logic [31:0]              load_data
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd4;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [63:0]        addr_reg;
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic               rsp_err_reg;
    logic               rsp_ok_reg;

    logic               accept;
    logic               enter_resp;
    logic [63:0]        dec_addr;
    logic [63:0]        dec_off;
    logic               dec_err;
    logic [IW-1:0]      dec_idx;
    logic [31:0]        rd_data;

    assign accept = (state_reg == IDLE) && req_ready_reg && req_valid;

    // With LATENCY==1 the read happens on the accept edge, so decode the live
    // address in IDLE and the captured one afterwards.
    assign dec_addr = (state_reg == IDLE) ? req_addr : addr_reg;
    // Modulo subtraction: addresses below BASE wrap to huge offsets.
    assign dec_off  = dec_addr - BASE;
    assign dec_err  = (dec_addr[1:0] != 2'b00) || (dec_off >= SPAN);
    assign dec_idx  = dec_off[IW+1:2];

    // Next-state and countdown logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_next   = CNT_W'(LATENCY - 2);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counter and registered handshake/response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_ok_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_ready_reg <= (state_next == IDLE);
            rsp_valid_reg <= (state_next == RESP);
            if (accept) begin
                addr_reg <= req_addr;
            end
            if (enter_resp) begin
                rsp_err_reg <= dec_err;
                rsp_ok_reg  <= ~dec_err;
            end
        end
    end

    ysyx_22050612_imem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .wr_en   (load_en),
        .wr_idx  (load_idx),
        .wr_data (load_data),
        .rd_en   (enter_resp && !dec_err),
        .rd_idx  (dec_idx),
        .rd_data (rd_data)
    );

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    // Faulted or not-yet-loaded responses read as the fault word.
    assign rsp_inst  = rsp_ok_reg ? rd_data : FAULT_INST;

endmodule

// File: tb/tb_ysyx_22050612_imem.sv
// Bench for the instruction-memory responder: two instances (LATENCY 1 and 4)
// share reset and the backdoor port, checked against an array model.
module tb_ysyx_22050612_imem;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [63:0] req_addr  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_inst  [2];
    logic        rsp_err   [2];
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    int          lat_of [2] = '{1, 4};
    logic [31:0] model_mem [DEPTH];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    ysyx_22050612_imem #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    ysyx_22050612_imem #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_fault(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE;
        return (addr % 4 != 0) || (off >= 64'(DEPTH) * 4);
    endfunction

    function automatic logic [31:0] model_word(input logic [63:0] addr);
        logic [63:0] off;
        off = addr - BASE;
        if (model_fault(addr)) return 32'h0;
        return model_mem[off / 4];
    endfunction

    // One complete fetch on instance k; optionally writes the fetched word
    // through the backdoor on the accept cycle.
    task automatic fetch(input int k, input logic [63:0] addr, input int hold,
                         input logic do_load, input logic [31:0] ld_data);
        logic        exp_err;
        logic [31:0] exp_inst;
        logic [63:0] off;
        int          lat;
        exp_err  = model_fault(addr);
        exp_inst = model_word(addr);
        off      = addr - BASE;
        check("ready_before_req", 64'(req_ready[k]), 64'd1);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        rsp_ready[k] = (hold == 0);
        if (do_load) begin
            load_en   = 1'b1;
            load_idx  = off[11:2];
            load_data = ld_data;
        end
        step();
        lat = 1;
        req_valid[k] = 1'b0;
        req_addr[k]  = {$urandom, $urandom};
        if (do_load) begin
            load_en = 1'b0;
            model_mem[off / 4] = ld_data;
        end
        while (!rsp_valid[k] && lat < 20) begin
            check("ready_low_in_wait", 64'(req_ready[k]), 64'd0);
            step();
            lat++;
        end
        check("latency", 64'(lat), 64'(lat_of[k]));
        check("rsp_inst", 64'(rsp_inst[k]), 64'(exp_inst));
        check("rsp_err", 64'(rsp_err[k]), 64'(exp_err));
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_valid", 64'(rsp_valid[k]), 64'd1);
            check("hold_inst", 64'(rsp_inst[k]), 64'(exp_inst));
            check("hold_err", 64'(rsp_err[k]), 64'(exp_err));
            check("hold_ready_low", 64'(req_ready[k]), 64'd0);
        end
        rsp_ready[k] = 1'b1;
        step();
        check("ready_after_hs", 64'(req_ready[k]), 64'd1);
        check("valid_after_hs", 64'(rsp_valid[k]), 64'd0);
        rsp_ready[k] = 1'b0;
        $display("[TB] fetch dut%0d addr=%h inst=%h err=%0d lat=%0d hold=%0d",
                 k, addr, exp_inst, exp_err, lat, hold);
    endtask

    initial begin
        logic [63:0] a;
        int          k;
        int          cls;

        rst = 1'b1;
        load_en = 1'b0;
        load_idx = '0;
        load_data = '0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_addr[i]  = '0;
            rsp_ready[i] = 1'b0;
        end
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready", 64'(req_ready[i]), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
            check("rst_rsp_inst", 64'(rsp_inst[i]), 64'd0);
            check("rst_rsp_err", 64'(rsp_err[i]), 64'd0);
        end

        // Preload the whole image while reset is held.
        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_idx  = 10'(i);
            load_data = (i == 0) ? 32'h0000_0413 :
                        (i == 2) ? 32'h0010_0073 :
                        (i == 3) ? 32'h1234_5678 : $urandom;
            model_mem[i] = load_data;
            step();
        end
        load_en = 1'b0;

        rst = 1'b0;
        check("ready_low_at_rst_edge", 64'(req_ready[0]), 64'd0);
        step();
        check("ready_after_rst_l1", 64'(req_ready[0]), 64'd1);
        check("ready_after_rst_l4", 64'(req_ready[1]), 64'd1);

        // Directed fetches.
        fetch(0, 64'h8000_0000, 0, 1'b0, 32'h0);
        fetch(1, 64'h8000_0008, 0, 1'b0, 32'h0);
        fetch(1, 64'h8000_0008, 5, 1'b0, 32'h0);
        fetch(0, 64'h8000_0002, 0, 1'b0, 32'h0);
        fetch(1, 64'h8000_0002, 1, 1'b0, 32'h0);
        fetch(0, 64'h8000_1000, 0, 1'b0, 32'h0);
        fetch(1, 64'h8000_1000, 0, 1'b0, 32'h0);
        fetch(0, 64'h7FFF_FFFC, 2, 1'b0, 32'h0);
        fetch(1, 64'h7FFF_FFFC, 0, 1'b0, 32'h0);
        fetch(0, 64'h8000_0FFC, 0, 1'b0, 32'h0);

        // Write landing on the read edge: old word first, then the new one.
        fetch(0, 64'h8000_000C, 0, 1'b1, 32'hDEAD_BEEF);
        fetch(0, 64'h8000_000C, 0, 1'b0, 32'h0);
        check("rbw_new_word", 64'(rsp_inst[0]), 64'h0000_0000_DEAD_BEEF);

        // Reset while the LATENCY=4 instance is counting down.
        req_valid[1] = 1'b1;
        req_addr[1]  = 64'h8000_0010;
        rsp_ready[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ready_low_after_mid_rst", 64'(req_ready[1]), 64'd0);
        step();
        check("ready_after_mid_rst", 64'(req_ready[1]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("no_rsp_after_rst", 64'(rsp_valid[1]), 64'd0);
            step();
        end
        rsp_ready[1] = 1'b0;
        $display("[TB] reset in WAIT dropped the pending fetch");

        // Randomized fetches across all address classes.
        for (int n = 0; n < 40; n++) begin
            k   = int'($urandom_range(0, 1));
            cls = int'($urandom_range(0, 4));
            case (cls)
                0: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
                1: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
                2: a = BASE + 64'(DEPTH * 4) + 64'(4 * $urandom_range(0, 1 << 20));
                3: a = BASE - 64'(4 * $urandom_range(1, 1000));
                default: a = {$urandom, $urandom};
            endcase
            fetch(k, a, int'($urandom_range(0, 3)),
                  (cls == 0) && ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
